// File: rtl/cpu_defs.sv
// Purpose: shared CPU front-end definitions used by IF, ID and the hazard unit.
// Contents: address/data widths, bubble instruction, skid-buffer state
// encoding, the {pc, instr} word carried by the skid, and a PC increment helper.
package cpu_defs;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  // sll $0,$0,0
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic SKID_EMPTY = 1'b0;
  localparam logic SKID_FULL  = 1'b1;

  typedef enum logic {
    SKID_ST_EMPTY = SKID_EMPTY,
    SKID_ST_FULL  = SKID_FULL
  } skid_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_word_t;

  // Next sequential word address; wraps 0xFFFF -> 0x0000.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Purpose: bundle of the fetch stage's PC handshake, imem read port,
// ID-stage control and IF/ID pipeline register outputs.
// Modports: slave  - the fetch stage itself
//           master - the surrounding PC / imem / decode logic
interface if_id_fetch_stage_if;
  import cpu_defs::*;

  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              stall_id;
  logic              flush;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc1;
  logic [DATA_W-1:0] if_id_instr;
  logic              if_id_valid;

  modport slave (
    input  pc_in, pc_valid, stall_id, flush, imem_rdata,
    output pc_ready, imem_en, imem_addr,
           if_id_pc, if_id_pc1, if_id_instr, if_id_valid
  );

  modport master (
    output pc_in, pc_valid, stall_id, flush, imem_rdata,
    input  pc_ready, imem_en, imem_addr,
           if_id_pc, if_id_pc1, if_id_instr, if_id_valid
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Purpose: one-entry {pc, instr} holding register that catches an imem
// return arriving while decode is stalled.
// Ports: CLK, RST (async, active-high)
//        load/load_word - capture a returning word (only from EMPTY)
//        drain          - release the held word (FULL -> EMPTY)
//        clear          - discard contents; wins over load and drain
//        full, word     - occupancy flag and held word
module fetch_skid_buf
  import cpu_defs::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  fetch_word_t load_word,
  input  logic        drain,
  input  logic        clear,
  output logic        full,
  output fetch_word_t word
);

  skid_state_t state;

  // EMPTY/FULL state and held word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= SKID_ST_EMPTY;
      word  <= '0;
    end else begin
      case (state)
        SKID_ST_EMPTY: begin
          if (load && !clear) begin
            state <= SKID_ST_FULL;
            word  <= load_word;
          end
        end
        SKID_ST_FULL: begin
          if (clear || drain) state <= SKID_ST_EMPTY;
        end
        default: state <= SKID_ST_EMPTY;
      endcase
    end
  end

  assign full = (state == SKID_ST_FULL);

endmodule

// File: rtl/if_id_fetch_stage.sv
// Purpose: instruction-fetch stage. Issues the PC to a 1-cycle synchronous
// imem, tracks the outstanding read, and loads the IF/ID register with
// {pc, pc+1, instr, valid}, using a 1-entry skid so a word returning
// during a decode stall is never lost. Flush squashes everything younger.
// Ports: CLK, RST (async, active-high)
//        bus (slave) - pc_in/pc_valid/pc_ready, stall_id, flush,
//                      imem_en/imem_addr/imem_rdata, if_id_* outputs
//        pc_ready, imem_en and imem_addr are combinational.
module if_id_fetch_stage
  import cpu_defs::*;
(
  input  logic               CLK,
  input  logic               RST,
  if_id_fetch_stage_if.slave bus
);

  logic              rst_q;
  logic              pc_ready_c;
  logic              accept_c;
  logic              inflight;
  logic [ADDR_W-1:0] req_pc;
  logic              skid_full;
  logic              skid_load_c;
  logic              skid_drain_c;
  fetch_word_t       skid_word;
  fetch_word_t       ret_word_c;

  // Hold off issue for one cycle after reset so a stale imem return is ignored
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rst_q <= 1'b1;
    else     rst_q <= 1'b0;
  end

  // Issue: never while the skid is occupied, so a return cannot collide with a drain
  assign pc_ready_c    = !rst_q && !bus.flush && !bus.stall_id && !skid_full;
  assign accept_c      = bus.pc_valid && pc_ready_c;
  assign bus.pc_ready  = pc_ready_c;
  assign bus.imem_en   = accept_c;
  assign bus.imem_addr = bus.pc_in;

  // Outstanding read tracking
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight <= 1'b0;
      req_pc   <= '0;
    end else begin
      inflight <= accept_c;
      if (accept_c) req_pc <= bus.pc_in;
    end
  end

  assign ret_word_c   = '{pc: req_pc, instr: bus.imem_rdata};
  assign skid_load_c  = inflight && bus.stall_id && !bus.flush;
  assign skid_drain_c = !bus.stall_id && !bus.flush;

  fetch_skid_buf u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .load      (skid_load_c),
    .load_word (ret_word_c),
    .drain     (skid_drain_c),
    .clear     (bus.flush),
    .full      (skid_full),
    .word      (skid_word)
  );

  // IF/ID register: flush > stall-hold > skid drain > fresh return > bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.if_id_pc    <= '0;
      bus.if_id_pc1   <= ADDR_W'(1);
      bus.if_id_instr <= NOP_INSTR;
      bus.if_id_valid <= 1'b0;
    end else if (bus.flush) begin
      bus.if_id_instr <= NOP_INSTR;
      bus.if_id_valid <= 1'b0;
    end else if (!bus.stall_id) begin
      if (skid_full) begin
        bus.if_id_pc    <= skid_word.pc;
        bus.if_id_pc1   <= pc_next(skid_word.pc);
        bus.if_id_instr <= skid_word.instr;
        bus.if_id_valid <= 1'b1;
      end else if (inflight) begin
        bus.if_id_pc    <= req_pc;
        bus.if_id_pc1   <= pc_next(req_pc);
        bus.if_id_instr <= bus.imem_rdata;
        bus.if_id_valid <= 1'b1;
      end else begin
        bus.if_id_instr <= NOP_INSTR;
        bus.if_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Purpose: self-checking bench for if_id_fetch_stage. A transaction-queue
// model predicts pc_ready/imem_en and the IF/ID outputs every cycle;
// directed scenarios add hand-computed IF/ID expectations.
module tb_if_id_fetch_stage;
  import cpu_defs::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  if_id_fetch_stage_if bus ();

  if_id_fetch_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // 256x32 synchronous ROM, mem[i] = 0x2000_0000 | i
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | 32'(i);
  always @(posedge CLK) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr[7:0]];

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return 32'h2000_0000 | {24'h0, a[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of fetched-but-undelivered PCs; 'parked' marks a word that came back during a stall
  typedef struct {
    logic [15:0] pc;
    bit          parked;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_ent;
  bit          m_rst_q = 1'b1;
  bit          m_acc;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_pc1   = 16'h0001;
  logic [31:0] m_instr = 32'h0;
  bit          m_valid = 1'b0;

  function automatic bit m_parked();
    foreach (mq[i]) if (mq[i].parked) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !m_rst_q && !bus.flush && !bus.stall_id && !m_parked();
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_rst_q = 1'b1;
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc    = 16'h0000;
      m_pc1   = 16'h0001;
    end else begin
      m_acc = bus.pc_valid && m_ready();
      if (bus.flush) begin
        mq.delete();
        m_valid = 1'b0;
        m_instr = 32'h0;
      end else if (!bus.stall_id) begin
        if (mq.size() > 0) begin
          m_ent   = mq.pop_front();
          m_pc    = m_ent.pc;
          m_pc1   = m_ent.pc + 16'd1;
          m_instr = rom_word(m_ent.pc);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_instr = 32'h0;
        end
      end else begin
        foreach (mq[i]) mq[i].parked = 1'b1;
      end
      if (m_acc) mq.push_back('{pc: bus.pc_in, parked: 1'b0});
      m_rst_q = 1'b0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge CLK) begin
    check("pc_ready", 32'(bus.pc_ready), 32'(m_ready()));
    check("imem_en", 32'(bus.imem_en), 32'(bus.pc_valid && m_ready()));
    if (bus.pc_valid && m_ready()) check("imem_addr", 32'(bus.imem_addr), 32'(bus.pc_in));
    check("m_if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    check("m_if_id_instr", bus.if_id_instr, m_instr);
    check("m_if_id_pc", 32'(bus.if_id_pc), 32'(m_pc));
    check("m_if_id_pc1", 32'(bus.if_id_pc1), 32'(m_pc1));
  end

  // One clock; the PC advances like Program_Counter when it was accepted
  task automatic tick();
    bit adv;
    @(negedge CLK);
    adv = bus.pc_valid && bus.pc_ready;
    @(posedge CLK);
    #1;
    if (adv) bus.pc_in = bus.pc_in + 16'd1;
  endtask

  task automatic expect_ifid(input string tag, input bit v, input logic [15:0] pc,
                             input logic [15:0] pc1, input logic [31:0] ins);
    #1;
    check({tag, "_valid"}, 32'(bus.if_id_valid), 32'(v));
    check({tag, "_pc"}, 32'(bus.if_id_pc), 32'(pc));
    check({tag, "_pc1"}, 32'(bus.if_id_pc1), 32'(pc1));
    check({tag, "_instr"}, bus.if_id_instr, ins);
  endtask

  initial begin
    bus.pc_in    = 16'h0000;
    bus.pc_valid = 1'b0;
    bus.stall_id = 1'b0;
    bus.flush    = 1'b0;

    // Reset state
    tick();
    tick();
    expect_ifid("rst", 1'b0, 16'h0000, 16'h0001, 32'h0);
    check("rst_ready", 32'(bus.pc_ready), 32'h0);
    RST = 1'b0;
    bus.pc_valid = 1'b1;
    #1;
    check("rst_q_ready", 32'(bus.pc_ready), 32'h0);

    // Streaming pc 0..3 back to back
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_ifid($sformatf("stream%0d", k), 1'b1, 16'(k), 16'(k + 1), 32'h2000_0000 | 32'(k));
    end

    // Stall while pc=4 returns: IF/ID holds pc=3, no issue
    bus.stall_id = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_ifid($sformatf("stall%0d", k), 1'b1, 16'h0003, 16'h0004, 32'h2000_0003);
      check($sformatf("stall%0d_ready", k), 32'(bus.pc_ready), 32'h0);
    end
    bus.stall_id = 1'b0;
    tick();
    expect_ifid("drain", 1'b1, 16'h0004, 16'h0005, 32'h2000_0004);
    tick();
    expect_ifid("post_drain", 1'b0, 16'h0004, 16'h0005, 32'h0);
    tick();
    expect_ifid("resume5", 1'b1, 16'h0005, 16'h0006, 32'h2000_0005);

    // Flush on pc=6 return, redirect to 0x40
    bus.flush = 1'b1;
    bus.pc_in = 16'h0040;
    tick();
    expect_ifid("flush", 1'b0, 16'h0005, 16'h0006, 32'h0);
    bus.flush = 1'b0;
    tick();
    expect_ifid("flush_gap", 1'b0, 16'h0005, 16'h0006, 32'h0);
    tick();
    expect_ifid("redirect", 1'b1, 16'h0040, 16'h0041, 32'h2000_0040);

    // Fill the skid with 0x41, then flush+stall together
    bus.stall_id = 1'b1;
    tick();
    expect_ifid("skid_fill", 1'b1, 16'h0040, 16'h0041, 32'h2000_0040);
    bus.flush = 1'b1;
    bus.pc_in = 16'h0080;
    tick();
    expect_ifid("flush_stall", 1'b0, 16'h0040, 16'h0041, 32'h0);
    bus.flush    = 1'b0;
    bus.stall_id = 1'b0;
    tick();
    expect_ifid("no_stale", 1'b0, 16'h0040, 16'h0041, 32'h0);
    tick();
    expect_ifid("redirect80", 1'b1, 16'h0080, 16'h0081, 32'h2000_0080);

    // pc_valid low gives a bubble, then wrap at 0xFFFF
    bus.pc_valid = 1'b0;
    tick();
    expect_ifid("last81", 1'b1, 16'h0081, 16'h0082, 32'h2000_0081);
    tick();
    expect_ifid("idle", 1'b0, 16'h0081, 16'h0082, 32'h0);
    bus.pc_in    = 16'hFFFF;
    bus.pc_valid = 1'b1;
    tick();
    expect_ifid("idle2", 1'b0, 16'h0081, 16'h0082, 32'h0);
    tick();
    expect_ifid("wrap", 1'b1, 16'hFFFF, 16'h0000, 32'h2000_00FF);
    tick();
    expect_ifid("wrap0", 1'b1, 16'h0000, 16'h0001, 32'h2000_0000);

    // Reset mid-run with pc=1 in flight
    RST = 1'b1;
    expect_ifid("rst_mid", 1'b0, 16'h0000, 16'h0001, 32'h0);
    check("rst_mid_ready", 32'(bus.pc_ready), 32'h0);
    tick();
    RST = 1'b0;
    #1;
    check("rst_fall_ready", 32'(bus.pc_ready), 32'h0);
    tick();
    expect_ifid("rst_rel1", 1'b0, 16'h0000, 16'h0001, 32'h0);
    tick();
    expect_ifid("rst_rel2", 1'b0, 16'h0000, 16'h0001, 32'h0);
    tick();
    expect_ifid("rst_resume", 1'b1, 16'h0002, 16'h0003, 32'h2000_0002);

    bus.pc_valid = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
